// File: rtl/dsp_pkg.sv
// Shared DSP definitions: coefficient-controller FSM encoding and the
// coefficient address map used by the IIR blocks.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FLUSH = 2'd2
    } coeff_state_e;

    // b coefficients start at index 0; a coefficients follow b0..bN.
    localparam int B_BASE = 0;

    localparam int FLUSH_CNT_W = 8;

    function automatic int a_base(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/iir_coeff_ctrl.sv
// Double-buffered IIR coefficient controller: writes land in a shadow bank,
// a committed bank is swapped in on a sample boundary, then the filter is flushed.
module iir_coeff_ctrl
    import dsp_pkg::*;
#(
    parameter int N            = 2,
    parameter int COEFF_WIDTH  = 16,
    parameter int FLUSH_CYCLES = 4,
    parameter logic [COEFF_WIDTH-1:0] RESET_B0 = 16'h4000,
    localparam int ADDR_W      = $clog2(2*N+1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic                         commit_valid,
    output logic                         commit_ready,
    input  logic                         sample_strobe,
    output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
    output logic                         filt_rst_n,
    output logic                         busy,
    output logic                         addr_err
);

    localparam int NUM_COEFFS = 2*N + 1;
    localparam int A_BASE     = a_base(N);
    localparam logic [ADDR_W-1:0]      MAX_ADDR  = ADDR_W'(2*N);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LEN = FLUSH_CNT_W'(FLUSH_CYCLES);

    coeff_state_e           state_reg;
    logic [FLUSH_CNT_W-1:0] cnt_reg;
    logic                   addr_err_reg;

    logic [COEFF_WIDTH-1:0] shadow_reg [NUM_COEFFS];
    logic [COEFF_WIDTH-1:0] active_reg [NUM_COEFFS];

    logic idle;
    logic wr_accept;
    logic wr_in_range;
    logic commit_accept;
    logic swap;

    assign idle          = (state_reg == ST_IDLE);
    assign wr_accept     = ~rst & idle & wr_valid;
    assign wr_in_range   = (wr_addr <= MAX_ADDR);
    assign commit_accept = ~rst & idle & commit_valid;
    // A strobe only counts once the commit has already moved us into ARMED.
    assign swap          = ~rst & (state_reg == ST_ARMED) & sample_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            if (wr_accept && !wr_in_range)
                addr_err_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (commit_accept)
                        state_reg <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (sample_strobe) begin
                        state_reg <= ST_FLUSH;
                        cnt_reg   <= FLUSH_LEN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_reg <= FLUSH_CNT_W'(1)) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // One register pair per coefficient; b0 is the only non-zero reset value.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFFS; gi++) begin : g_bank
            localparam logic [COEFF_WIDTH-1:0] INIT = (gi == B_BASE) ? RESET_B0 : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= INIT;
                    active_reg[gi] <= INIT;
                end else begin
                    if (wr_accept && wr_in_range && (wr_addr == ADDR_W'(gi)))
                        shadow_reg[gi] <= wr_data;
                    if (swap)
                        active_reg[gi] <= shadow_reg[gi];
                end
            end
        end

        for (gi = 0; gi <= N; gi++) begin : g_b_out
            assign packed_b_coeffs[COEFF_WIDTH*gi +: COEFF_WIDTH] = active_reg[B_BASE + gi];
        end

        for (gi = 1; gi <= N; gi++) begin : g_a_out
            assign packed_a_coeffs[COEFF_WIDTH*(gi-1) +: COEFF_WIDTH] = active_reg[A_BASE + gi - 1];
        end
    endgenerate

    // Handshake and filter reset are forced inactive/asserted while rst is held.
    assign wr_ready     = ~rst & idle;
    assign commit_ready = ~rst & idle;
    assign busy         = ~rst & ~idle;
    assign filt_rst_n   = ~rst & (state_reg != ST_FLUSH);
    assign addr_err     = addr_err_reg;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Self-checking bench for iir_coeff_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_iir_coeff_ctrl;

    localparam int N     = 2;
    localparam int CW    = 16;
    localparam int FLUSH = 4;
    localparam int NC    = 2*N + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          commit_valid = 1'b0;
    logic          commit_ready;
    logic          sample_strobe = 1'b0;
    logic [47:0]   packed_b_coeffs;
    logic [31:0]   packed_a_coeffs;
    logic          filt_rst_n;
    logic          busy;
    logic          addr_err;

    iir_coeff_ctrl #(.N(N), .COEFF_WIDTH(CW), .FLUSH_CYCLES(FLUSH), .RESET_B0(16'h4000)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .sample_strobe(sample_strobe),
        .packed_b_coeffs(packed_b_coeffs), .packed_a_coeffs(packed_a_coeffs),
        .filt_rst_n(filt_rst_n), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Behavioural model: a pending-swap flag and a remaining-flush count.
    logic [CW-1:0] m_sh [NC];
    logic [CW-1:0] m_ac [NC];
    bit            m_pending = 1'b0;
    int            m_flush   = 0;
    bit            m_err     = 1'b0;

    function automatic logic m_ready(input logic r);
        return !r && !m_pending && (m_flush == 0);
    endfunction

    function automatic logic [47:0] m_b();
        return {m_ac[2], m_ac[1], m_ac[0]};
    endfunction

    function automatic logic [31:0] m_a();
        return {m_ac[4], m_ac[3]};
    endfunction

    task automatic model_update(input logic r, wv, input logic [2:0] wa,
                                input logic [CW-1:0] wd, input logic cv, ss);
        if (r) begin
            for (int i = 0; i < NC; i++) begin
                m_sh[i] = (i == 0) ? 16'h4000 : 16'h0000;
                m_ac[i] = m_sh[i];
            end
            m_pending = 1'b0;
            m_flush   = 0;
            m_err     = 1'b0;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_pending) begin
            if (ss) begin
                for (int i = 0; i < NC; i++) m_ac[i] = m_sh[i];
                m_pending = 1'b0;
                m_flush   = FLUSH;
            end
        end else begin
            if (wv) begin
                if (int'(wa) <= 2*N) m_sh[wa] = wd;
                else m_err = 1'b1;
            end
            if (cv) m_pending = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic step(input logic r, wv, input logic [2:0] wa,
                        input logic [CW-1:0] wd, input logic cv, ss);
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        commit_valid = cv; sample_strobe = ss;
        #1;
        chk("wr_ready_pre", 64'(wr_ready), 64'(m_ready(r)));
        chk("commit_ready_pre", 64'(commit_ready), 64'(m_ready(r)));
        @(posedge clk);
        model_update(r, wv, wa, wd, cv, ss);
        cycle++;
        #1;
        chk("packed_b", 64'(packed_b_coeffs), 64'(m_b()));
        chk("packed_a", 64'(packed_a_coeffs), 64'(m_a()));
        chk("filt_rst_n", 64'(filt_rst_n), 64'(!r && m_flush == 0));
        chk("busy", 64'(busy), 64'(!r && (m_pending || m_flush > 0)));
        chk("wr_ready", 64'(wr_ready), 64'(m_ready(r)));
        chk("addr_err", 64'(addr_err), 64'(m_err));
        $display("cyc %0d rst=%b wv=%b wa=%0d wd=%h cv=%b ss=%b -> b=%h a=%h frn=%b busy=%b rdy=%b err=%b",
                 cycle, r, wv, wa, wd, cv, ss, packed_b_coeffs, packed_a_coeffs,
                 filt_rst_n, busy, wr_ready, addr_err);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        r, wv;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        cv, ss;
        logic [47:0] eb;
        logic [31:0] ea;
        logic        efrn, ebusy, erdy, eerr;
    } vec_t;

    localparam logic [47:0] B_RST = 48'h0000_0000_4000;
    localparam logic [47:0] B_NEW = 48'h0000_1234_4000;
    localparam logic [31:0] A_NEW = 32'hFF00_0000;

    vec_t vecs [15];

    initial begin
        for (int i = 0; i < NC; i++) begin
            m_sh[i] = '0;
            m_ac[i] = '0;
        end

        //          r  wv wa  wd       cv ss  exp b  exp a         frn busy rdy err
        vecs[0]  = '{1, 0, 0, 16'h0000, 0, 0, B_RST, 32'h0,       0,  0,   0,  0};
        vecs[1]  = '{1, 0, 0, 16'h0000, 0, 0, B_RST, 32'h0,       0,  0,   0,  0};
        vecs[2]  = '{0, 0, 0, 16'h0000, 0, 0, B_RST, 32'h0,       1,  0,   1,  0};
        vecs[3]  = '{0, 1, 1, 16'h1234, 0, 0, B_RST, 32'h0,       1,  0,   1,  0};
        vecs[4]  = '{0, 1, 4, 16'hFF00, 0, 0, B_RST, 32'h0,       1,  0,   1,  0};
        vecs[5]  = '{0, 0, 0, 16'h0000, 1, 0, B_RST, 32'h0,       1,  1,   0,  0};
        vecs[6]  = '{0, 0, 0, 16'h0000, 0, 0, B_RST, 32'h0,       1,  1,   0,  0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 0, 0, B_RST, 32'h0,       1,  1,   0,  0};
        vecs[8]  = '{0, 0, 0, 16'h0000, 0, 1, B_NEW, A_NEW,       0,  1,   0,  0};
        vecs[9]  = '{0, 0, 0, 16'h0000, 0, 0, B_NEW, A_NEW,       0,  1,   0,  0};
        vecs[10] = '{0, 0, 0, 16'h0000, 0, 0, B_NEW, A_NEW,       0,  1,   0,  0};
        vecs[11] = '{0, 0, 0, 16'h0000, 0, 0, B_NEW, A_NEW,       0,  1,   0,  0};
        vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, B_NEW, A_NEW,       1,  0,   1,  0};
        vecs[13] = '{0, 1, 5, 16'hAAAA, 0, 0, B_NEW, A_NEW,       1,  0,   1,  1};
        vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, B_NEW, A_NEW,       1,  0,   1,  1};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].cv, vecs[i].ss);
            chk("vec_b", 64'(packed_b_coeffs), 64'(vecs[i].eb));
            chk("vec_a", 64'(packed_a_coeffs), 64'(vecs[i].ea));
            chk("vec_frn", 64'(filt_rst_n), 64'(vecs[i].efrn));
            chk("vec_busy", 64'(busy), 64'(vecs[i].ebusy));
            chk("vec_rdy", 64'(commit_ready), 64'(vecs[i].erdy));
            chk("vec_err", 64'(addr_err), 64'(vecs[i].eerr));
        end

        // Write, commit and strobe together: strobe ignored, next strobe swaps.
        step(1'b0, 1'b1, 3'd2, 16'h0BBB, 1'b1, 1'b1);
        chk("same_cycle_no_swap_b", 64'(packed_b_coeffs), 64'(B_NEW));
        chk("same_cycle_busy", 64'(busy), 64'(1));
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        chk("same_cycle_swap_b", 64'(packed_b_coeffs), 64'h0BBB_1234_4000);
        chk("same_cycle_swap_frn", 64'(filt_rst_n), 64'(0));
        idle_steps(FLUSH);
        chk("same_cycle_done_busy", 64'(busy), 64'(0));

        // Requests held through ARMED and FLUSH, accepted on the first IDLE cycle.
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 16'h5555, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 16'h5555, 1'b1, 1'b1);
        chk("held_b0_unchanged", 64'(packed_b_coeffs[15:0]), 64'h4000);
        for (int i = 0; i < FLUSH; i++) step(1'b0, 1'b1, 3'd0, 16'h5555, 1'b1, 1'b0);
        chk("held_ready_idle", 64'(wr_ready), 64'(1));
        step(1'b0, 1'b1, 3'd0, 16'h5555, 1'b1, 1'b0);
        chk("held_commit_taken", 64'(busy), 64'(1));
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        chk("held_write_applied", 64'(packed_b_coeffs[15:0]), 64'h5555);
        idle_steps(FLUSH);

        // Reset on the second FLUSH cycle discards the swap and the shadow bank.
        step(1'b0, 1'b1, 3'd2, 16'h7FFF, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        chk("abort_b", 64'(packed_b_coeffs), 64'(B_RST));
        chk("abort_a", 64'(packed_a_coeffs), 64'(0));
        chk("abort_frn", 64'(filt_rst_n), 64'(0));
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        chk("abort_release_frn", 64'(filt_rst_n), 64'(1));
        chk("abort_release_busy", 64'(busy), 64'(0));
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        chk("abort_shadow_discarded", 64'(packed_b_coeffs), 64'(B_RST));
        idle_steps(FLUSH);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_coeff_ctrl.md
IIR_COEFF_CTRL -- requirements
Module: iir_coeff_ctrl

Interface
REQ-001 Parameter N, default 2: filter order; the block serves N+1 b coefficients and N a coefficients.
REQ-002 Parameter COEFF_WIDTH, default 16: width of one coefficient in bits.
REQ-003 Parameter FLUSH_CYCLES, default 4: number of cycles the filter is held in reset after a swap; legal range 1..255.
REQ-004 Parameter RESET_B0, default 16'h4000: b0 value loaded at reset; all other coefficients reset to 0.
REQ-005 clk  in  1  single clock; every register is clocked on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 wr_valid  in  1  coefficient write request.
REQ-008 wr_ready  out  1  write accepted when high together with wr_valid.
REQ-009 wr_addr  in  ADDR_W = $clog2(2N+1)  coefficient index: 0..N selects b0..bN; N+1..2N selects a1..aN.
REQ-010 wr_data  in  COEFF_WIDTH  signed coefficient value.
REQ-011 commit_valid  in  1  request to make the shadow bank active.
REQ-012 commit_ready  out  1  commit accepted when high together with commit_valid.
REQ-013 sample_strobe  in  1  one-cycle pulse marking the filter's sample boundary.
REQ-014 packed_b_coeffs  out  COEFF_WIDTH*(N+1)  active b bank; bk occupies bits [COEFF_WIDTH*(k+1)-1 : COEFF_WIDTH*k].
REQ-015 packed_a_coeffs  out  COEFF_WIDTH*N  active a bank; ak occupies slice k-1.
REQ-016 filt_rst_n  out  1  active-low reset for the filter datapath.
REQ-017 busy  out  1  high in states ARMED and FLUSH.
REQ-018 addr_err  out  1  sticky flag set by an out-of-range write.

Function
REQ-019 The block SHALL hold two registered banks, shadow and active; the outputs SHALL always drive the active bank directly from registers.
REQ-020 The FSM SHALL have three states: IDLE, ARMED and FLUSH.
REQ-021 In IDLE: wr_ready=1 and commit_ready=1; in ARMED and FLUSH: wr_ready=0 and commit_ready=0.
REQ-022 An accepted write SHALL update only the addressed shadow entry, on the next clock edge.
REQ-023 A write with wr_addr > 2N SHALL be accepted, SHALL NOT modify any register bank, and SHALL set addr_err.
REQ-024 addr_err SHALL be cleared only by rst.
REQ-025 An accepted commit SHALL move the FSM from IDLE to ARMED.
REQ-026 A write and a commit accepted in the same cycle SHALL both take effect; that write SHALL be part of the committed bank.
REQ-027 An accepted commit SHALL ignore sample_strobe in its acceptance cycle; only a strobe seen while in ARMED counts.
REQ-028 In ARMED, the first sample_strobe SHALL copy the entire shadow bank to the active bank at that edge, load the flush counter with FLUSH_CYCLES, and enter FLUSH.
REQ-029 The outputs SHALL therefore change exactly one cycle after the triggering strobe.
REQ-030 In FLUSH, filt_rst_n SHALL be 0 for exactly FLUSH_CYCLES cycles, starting the cycle the new coefficients appear.
REQ-031 When the flush counter expires, the FSM SHALL return to IDLE and drive filt_rst_n=1.
REQ-032 filt_rst_n SHALL be 1 in IDLE and in ARMED.
REQ-033 sample_strobe SHALL be ignored in IDLE and in FLUSH.
REQ-034 The shadow bank SHALL be retained after a commit, so a later commit with no writes re-applies the same values.
REQ-035 No coefficient arithmetic SHALL be performed; values pass through unmodified.

Reset
REQ-036 While rst=1, both banks SHALL load b0=RESET_B0 and all other coefficients = 0.
REQ-037 While rst=1, the FSM SHALL go to IDLE, the counter SHALL clear, and addr_err SHALL be 0.
REQ-038 While rst=1, filt_rst_n=0, busy=0, wr_ready=0 and commit_ready=0.
REQ-039 After rst is released, filt_rst_n=1 and the ready signals SHALL go high in the first cycle.
REQ-040 A reset asserted in ARMED or FLUSH SHALL abort the pending swap; any pending shadow contents SHALL be discarded.

Structure
REQ-041 The FSM state encoding and the address-map constants (B_BASE=0, A_BASE=N+1) SHALL live in the shared package dsp_pkg.
REQ-042 The block SHALL be a single module with no sub-modules.
REQ-043 The output ports SHALL connect directly to iir_df_i's packed_a_coeffs and packed_b_coeffs inputs, and filt_rst_n SHALL connect to its rst_n.

Verification (N=2, COEFF_WIDTH=16, FLUSH_CYCLES=4)
REQ-044 Scenario: reset -> packed_b=48'h0000_0000_4000, packed_a=0, filt_rst_n=0 during reset and 1 the cycle after release.
REQ-045 Scenario: write b1=16'h1234, a2=16'hFF00, then commit, then strobe 3 cycles later -> outputs unchanged until 1 cycle after the strobe; then packed_b=48'h0000_1234_4000 and packed_a=32'hFF00_0000; filt_rst_n low for exactly 4 cycles; busy low again after the flush.
REQ-046 Scenario: wr_addr=5, wr_data=16'hAAAA -> wr_ready=1, addr_err=1 and stays set, both banks unchanged.
REQ-047 Scenario: write, commit and strobe all in the same cycle -> no swap on that strobe; the swap follows the next strobe and includes the write.
REQ-048 Scenario: wr_valid or commit_valid held high during ARMED and FLUSH -> not accepted (ready=0); accepted on the first IDLE cycle.
REQ-049 Scenario: rst pulse on the second FLUSH cycle after committing b2=16'h7FFF -> both banks return to reset values, FSM in IDLE, filt_rst_n=1 after release.
